muldiv_seq: RTL and testbench

Multi-cycle multiply/divide unit for the MIPS datapath. It accepts MULT/MULTU/DIV/DIVU requests from the execute stage over a start/busy/done handshake and iterates one bit per clock. It returns a registered 64-bit result on the HI/LO outputs. It replaces the single-cycle combinational multiply and divide currently feeding the HI/LO special-purpose registers.

---
 rtl/muldiv_seq_if.sv | 25 ++
 rtl/muldiv_seq.sv | 137 +++++++++++++
 tb/tb_muldiv_seq.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/muldiv_seq_if.sv
// Request/response bundle between the execute stage and the multiply/divide unit.
// The execute stage drives start/op/a/b; the unit returns busy/done and the HI/LO result.
interface muldiv_seq_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             div_by_zero;

  modport master (
    output start, op, a, b,
    input  busy, done, hi, lo, div_by_zero
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, hi, lo, div_by_zero
  );
endinterface

// File: rtl/muldiv_seq.sv
// Sequential MULT/MULTU/DIV/DIVU: one bit per clock on magnitudes, sign fix-up in a final cycle.
// Fixed WIDTH+1 edge latency from accept to a registered HI/LO result.
module muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic        clock,
  input  logic        reset,
  muldiv_seq_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FIX = 2'd2} state_t;

  state_t             state_reg;
  logic [CW-1:0]      count_reg;
  logic               div_reg;
  logic               neg_a_reg;
  logic               neg_b_reg;
  logic [WIDTH-1:0]   a_reg;
  logic [WIDTH-1:0]   mag_a_reg;
  logic [WIDTH-1:0]   mag_b_reg;
  logic [WIDTH-1:0]   rem_reg;
  logic [2*WIDTH-1:0] acc_reg;
  logic               busy_reg;
  logic               done_reg;
  logic               dbz_reg;
  logic [WIDTH-1:0]   hi_reg;
  logic [WIDTH-1:0]   lo_reg;

  logic               in_neg_a;
  logic               in_neg_b;
  logic [WIDTH-1:0]   in_mag_a;
  logic [WIDTH-1:0]   in_mag_b;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH-1:0]   div_diff;
  logic               div_ge;
  logic [2*WIDTH-1:0] acc_next;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix;
  logic [WIDTH-1:0]   rem_fix;

  always_comb begin
    in_neg_a = bus.op[0] & bus.a[WIDTH-1];
    in_neg_b = bus.op[0] & bus.b[WIDTH-1];
    in_mag_a = in_neg_a ? -bus.a : bus.a;
    in_mag_b = in_neg_b ? -bus.b : bus.b;
    // Multiply: upper half accumulates, lower half holds the multiplier shifting out LSB first.
    mul_sum = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} + (acc_reg[0] ? {1'b0, mag_a_reg} : {(WIDTH+1){1'b0}});
    // Divide: the WIDTH+1 bit trial remainder; quotient bits shift into the lower half.
    div_shift = {rem_reg, acc_reg[WIDTH-1]};
    div_ge    = div_shift >= {1'b0, mag_b_reg};
    div_diff  = div_shift[WIDTH-1:0] - mag_b_reg;
    if (div_reg)
      acc_next = {acc_reg[2*WIDTH-1:WIDTH], acc_reg[WIDTH-2:0], div_ge};
    else
      acc_next = {mul_sum, acc_reg[WIDTH-1:1]};
    prod_fix = (neg_a_reg ^ neg_b_reg) ? -acc_reg : acc_reg;
    quot_fix = (neg_a_reg ^ neg_b_reg) ? -acc_reg[WIDTH-1:0] : acc_reg[WIDTH-1:0];
    rem_fix  = neg_a_reg ? -rem_reg : rem_reg;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      count_reg <= '0;
      div_reg   <= 1'b0;
      neg_a_reg <= 1'b0;
      neg_b_reg <= 1'b0;
      a_reg     <= '0;
      mag_a_reg <= '0;
      mag_b_reg <= '0;
      rem_reg   <= '0;
      acc_reg   <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      dbz_reg   <= 1'b0;
      hi_reg    <= '0;
      lo_reg    <= '0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.start) begin
            div_reg   <= bus.op[1];
            neg_a_reg <= in_neg_a;
            neg_b_reg <= in_neg_b;
            a_reg     <= bus.a;
            mag_a_reg <= in_mag_a;
            mag_b_reg <= in_mag_b;
            acc_reg   <= bus.op[1] ? {{WIDTH{1'b0}}, in_mag_a} : {{WIDTH{1'b0}}, in_mag_b};
            rem_reg   <= '0;
            count_reg <= '0;
            busy_reg  <= 1'b1;
            state_reg <= RUN;
          end
        end
        RUN: begin
          acc_reg <= acc_next;
          if (div_reg)
            rem_reg <= div_ge ? div_diff : div_shift[WIDTH-1:0];
          count_reg <= count_reg + 1'b1;
          if (count_reg == CW'(WIDTH - 1))
            state_reg <= FIX;
        end
        FIX: begin
          if (div_reg) begin
            // Divide by zero keeps the natural all-ones quotient but reports the untouched dividend.
            if (mag_b_reg == '0) begin
              dbz_reg <= 1'b1;
              lo_reg  <= '1;
              hi_reg  <= a_reg;
            end else begin
              dbz_reg <= 1'b0;
              lo_reg  <= quot_fix;
              hi_reg  <= rem_fix;
            end
          end else begin
            dbz_reg <= 1'b0;
            hi_reg  <= prod_fix[2*WIDTH-1:WIDTH];
            lo_reg  <= prod_fix[WIDTH-1:0];
          end
          busy_reg  <= 1'b0;
          done_reg  <= 1'b1;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.busy        = busy_reg;
  assign bus.done        = done_reg;
  assign bus.hi          = hi_reg;
  assign bus.lo          = lo_reg;
  assign bus.div_by_zero = dbz_reg;
endmodule

// File: tb/tb_muldiv_seq.sv
// Directed plus randomized bench for muldiv_seq; expected results come from 64-bit
// integer arithmetic on the original operands.
module tb_muldiv_seq;
  logic clock = 1'b0;
  logic reset;
  int   vectors = 0;
  int   miscompares = 0;

  muldiv_seq_if #(.WIDTH(32)) bus ();

  muldiv_seq #(.WIDTH(32)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: the architectural result of each op, computed with plain integer arithmetic.
  function automatic void model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] hi, output logic [31:0] lo, output logic dbz);
    longint      sa;
    longint      sb;
    longint      q;
    longint      r;
    logic [63:0] p;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    dbz = 1'b0;
    case (op)
      2'd0: begin p = {32'd0, a} * {32'd0, b}; hi = p[63:32]; lo = p[31:0]; end
      2'd1: begin p = sa * sb; hi = p[63:32]; lo = p[31:0]; end
      default: begin
        if (b == 32'd0) begin
          dbz = 1'b1; lo = 32'hFFFF_FFFF; hi = a;
        end else if (op == 2'd2) begin
          lo = a / b; hi = a % b;
        end else begin
          q = sa / sb; r = sa % sb;
          lo = q[31:0]; hi = r[31:0];
        end
      end
    endcase
  endfunction

  // Called at a negedge with the unit idle or in its done cycle; returns at the done-cycle negedge.
  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input bit hold, input string tag);
    logic [31:0] eh;
    logic [31:0] el;
    logic        ed;
    int          cyc;
    int          busy_cnt;
    model(op, a, b, eh, el, ed);
    bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
    @(negedge clock);
    if (!hold) bus.start = 1'b0;
    bus.a = $urandom; bus.b = $urandom; bus.op = 2'($urandom);
    cyc = 1; busy_cnt = 0;
    while (bus.done !== 1'b1 && cyc < 40) begin
      if (bus.busy === 1'b1) busy_cnt++;
      @(negedge clock);
      cyc++;
    end
    $display("%s: op=%0d a=%h b=%h -> hi=%h lo=%h dbz=%b latency=%0d", tag, op, a, b,
             bus.hi, bus.lo, bus.div_by_zero, cyc);
    chk({tag, "_latency"}, 64'(cyc), 64'd34);
    chk({tag, "_busy_cycles"}, 64'(busy_cnt), 64'd33);
    chk({tag, "_busy_at_done"}, 64'(bus.busy), 64'd0);
    chk({tag, "_hi"}, 64'(bus.hi), 64'(eh));
    chk({tag, "_lo"}, 64'(bus.lo), 64'(el));
    chk({tag, "_dbz"}, 64'(bus.div_by_zero), 64'(ed));
  endtask

  initial begin
    int          cyc;
    bit          done_seen;
    logic [1:0]  rop;
    logic [31:0] ra;
    logic [31:0] rb;

    reset = 1'b1;
    bus.start = 1'b0; bus.op = 2'd0; bus.a = '0; bus.b = '0;
    repeat (2) @(negedge clock);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_hi", 64'(bus.hi), 64'd0);
    chk("rst_lo", 64'(bus.lo), 64'd0);
    chk("rst_dbz", 64'(bus.div_by_zero), 64'd0);
    reset = 1'b0;
    @(negedge clock);

    do_op(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "multu_max");
    chk("multu_max_hi_const", 64'(bus.hi), 64'hFFFF_FFFE);
    chk("multu_max_lo_const", 64'(bus.lo), 64'h0000_0001);
    do_op(2'd1, 32'hFFFF_FFFD, 32'd5, 1'b0, "mult_neg3x5");
    chk("mult_neg3x5_lo_const", 64'(bus.lo), 64'hFFFF_FFF1);
    do_op(2'd3, 32'hFFFF_FFF9, 32'd2, 1'b0, "div_neg7by2");
    chk("div_neg7by2_hi_const", 64'(bus.hi), 64'hFFFF_FFFF);
    do_op(2'd2, 32'd100, 32'd7, 1'b0, "divu_100by7");
    do_op(2'd2, 32'd100, 32'd0, 1'b0, "divu_by0");
    do_op(2'd0, 32'd2, 32'd3, 1'b0, "multu_after_dbz");
    do_op(2'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "div_overflow");
    chk("div_overflow_lo_const", 64'(bus.lo), 64'h8000_0000);
    do_op(2'd3, 32'hFFFF_FFF9, 32'd0, 1'b0, "div_neg_by0");

    // Handshake part 1: a second start pulse while busy must be dropped.
    bus.start = 1'b1; bus.op = 2'd0; bus.a = 32'd2; bus.b = 32'd3;
    @(negedge clock);
    bus.start = 1'b0;
    cyc = 1;
    repeat (3) begin @(negedge clock); cyc++; end
    bus.start = 1'b1; bus.a = 32'd9; bus.b = 32'd9;
    @(negedge clock); cyc++;
    bus.start = 1'b0;
    while (bus.done !== 1'b1 && cyc < 40) begin @(negedge clock); cyc++; end
    $display("ignore_start: hi=%h lo=%h latency=%0d", bus.hi, bus.lo, cyc);
    chk("ignore_start_latency", 64'(cyc), 64'd34);
    chk("ignore_start_lo", 64'(bus.lo), 64'd6);
    chk("ignore_start_hi", 64'(bus.hi), 64'd0);
    @(negedge clock);
    chk("ignore_start_no_second_op", 64'(bus.busy), 64'd0);

    // Handshake part 2: start held high through busy; accepted again in each done cycle.
    do_op(2'd1, 32'h1234_5678, 32'hFEDC_BA98, 1'b1, "hold_1");
    do_op(2'd3, 32'h7FFF_FFFF, 32'hFFFF_FFFD, 1'b1, "hold_2");
    do_op(2'd2, 32'hDEAD_BEEF, 32'd16, 1'b0, "hold_3");

    for (int i = 0; i < 24; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = (i % 5 == 0) ? 32'h8000_0000 : $urandom;
      rb  = (i % 6 == 0) ? 32'd0 : (i % 6 == 1) ? 32'hFFFF_FFFF : (i % 6 == 2) ? 32'($urandom_range(1, 300)) : $urandom;
      do_op(rop, ra, rb, (i % 4 == 3), $sformatf("rand_%0d", i));
    end

    do_op(2'd2, 32'd77, 32'd0, 1'b0, "pre_reset_dbz");
    // Reset in the middle of a DIV: outputs clear at once and the result never appears.
    bus.start = 1'b1; bus.op = 2'd3; bus.a = 32'hFFFF_0001; bus.b = 32'd13;
    @(negedge clock);
    bus.start = 1'b0;
    repeat (9) @(negedge clock);
    reset = 1'b1;
    #1;
    chk("midrst_busy", 64'(bus.busy), 64'd0);
    chk("midrst_done", 64'(bus.done), 64'd0);
    chk("midrst_hi", 64'(bus.hi), 64'd0);
    chk("midrst_lo", 64'(bus.lo), 64'd0);
    chk("midrst_dbz", 64'(bus.div_by_zero), 64'd0);
    @(negedge clock);
    reset = 1'b0;
    done_seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (bus.done === 1'b1) done_seen = 1'b1;
    end
    $display("mid_reset: done_seen=%b", done_seen);
    chk("midrst_no_done", 64'(done_seen), 64'd0);
    do_op(2'd3, 32'hFFFF_FF9C, 32'd7, 1'b0, "after_reset");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
